// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle add/subtract sequencer, one lookahead slice per cycle
module cla_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int NG  = CHUNK / 2;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_d;
  logic   accept, last;

  logic [KW-1:0]               k;
  logic                        carry;
  logic [NCH-1:0][CHUNK-1:0]   opa, opb, sum_r, nsum;

  logic [CHUNK-1:0] sa, sb, sp, sg, ssum;
  logic [NG-1:0]    gp, gg, pp, pg;
  logic [NG:0]      cgrp;
  logic [CHUNK:0]   c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (k == KLAST) begin
        last    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_r;

  // Slice adder: 2-bit group P/G cells, then a log-depth prefix over groups
  always_comb begin
    sa = opa[k];
    sb = opb[k];
    sp = sa ^ sb;
    sg = sa & sb;
    for (int i = 0; i < NG; i++) begin
      gp[i] = sp[2*i+1] & sp[2*i];
      gg[i] = sg[2*i+1] | (sp[2*i+1] & sg[2*i]);
    end
    pp = gp;
    pg = gg;
    for (int d = 1; d < NG; d = d * 2) begin
      for (int i = NG - 1; i >= d; i--) begin
        pg[i] = pg[i] | (pp[i] & pg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    cgrp[0] = carry;
    for (int j = 1; j <= NG; j++) cgrp[j] = pg[j-1] | (pp[j-1] & carry);
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[2*j]   = cgrp[j];
      c[2*j+1] = sg[2*j] | (sp[2*j] & cgrp[j]);
    end
    c[CHUNK] = cgrp[NG];
    ssum     = sp ^ c[CHUNK-1:0];
    nsum     = sum_r;
    nsum[k]  = ssum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k     <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      sum_r <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b ^ {WIDTH{sub}};
      carry <= sub;
      k     <= '0;
    end else if (state == RUN) begin
      sum_r[k] <= ssum;
      carry    <= c[CHUNK];
      k        <= k + 1'b1;
      if (last) begin
        cout <= c[CHUNK];
        ovf  <= c[CHUNK-1] ^ c[CHUNK];
        zero <= (nsum == '0);
      end
    end
  end
endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle add/subtract sequencer for the ALU carry-lookahead datapath.
- Processes a WIDTH-bit operation one CHUNK-bit slice per cycle, least-significant slice first. The slice carry is registered between cycles.
- Each slice adder is a lookahead tree of 2-bit group propagate/generate cells.
- Sits beside the ALU. The control unit issues start/sub, waits for done, then samples the result and flags.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, slice width per cycle. Must be a power of 2, at least 2, and must divide WIDTH.
- NCH = WIDTH/CHUNK is derived, not overridable. Default NCH = 4.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only when the block accepts (IDLE or DONE)
- sub  input  1  0 = a+b, 1 = a-b (two's complement); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result register
- cout  output  1  carry out of MSB; for sub, 1 = no borrow
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; slice index k = 0; carry register = 0.
  - Operand registers = 0.
  - sum = 0, cout = 0, ovf = 0, zero = 0, busy = 0, done = 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - On start = 1 at a rising edge: latch opA = a, opB = b XOR {WIDTH{sub}}, carry = sub, k = 0.
  - Go to RUN.
  - sum and the flags keep their previous values until overwritten.
- RUN, at each rising edge:
  - Compute slice k from opA[k*CHUNK +: CHUNK], opB[same bits] and carry, using the lookahead slice.
  - Write the slice result into sum[k*CHUNK +: CHUNK].
  - carry <= slice carry out; k <= k + 1.
  - When k = NCH-1, do the following in the same edge, then go to DONE:
    - cout <= slice carry out.
    - ovf <= carry into bit WIDTH-1 XOR slice carry out.
    - zero <= (full next-sum == 0).
- DONE:
  - done = 1 for exactly this one cycle; busy = 0.
  - If start = 1, accept a new operation exactly as from IDLE and go to RUN. Back-to-back operations lose no cycle.
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0 gives done high in the cycle after edge E0+NCH. Default: done is visible NCH = 4 cycles after acceptance.
- busy is high from the edge after acceptance through the edge that writes the last slice.
- start while in RUN is ignored: no latch, no queueing. a, b and sub may change freely during RUN.
- The sum register is partially updated during RUN. It is valid only when done = 1 and thereafter, until the next accept.
- Flags are updated only on the last-slice edge. They hold their values in IDLE.
- Reset asserted mid-RUN aborts the operation:
  - All outputs return to their reset values.
  - done is not pulsed.
- Slice arithmetic:
  - Pair bits 2i and 2i+1 into groups. Group P = p1 & p0; group G = g1 | (p1 & g0).
  - Combine groups recursively to form the slice carry out and every internal carry.
  - No ripple chain longer than 2 bits.

Test Plan:
- a = 0xFFFFFFFF, b = 0x00000001, sub = 0 → after 4 cycles, done pulse; sum = 0x00000000, cout = 1, ovf = 0, zero = 1.
- a = 0x7FFFFFFF, b = 0x00000001, sub = 0 → sum = 0x80000000, cout = 0, ovf = 1, zero = 0.
- a = 5, b = 7, sub = 1 → sum = 0xFFFFFFFE, cout = 0, ovf = 0. Then a = 7, b = 5, sub = 1 → sum = 0x00000002, cout = 1.
- Accept a = 0x12345678 + b = 0x11111111, then pulse start with a = 0, b = 0 on the 2nd RUN cycle → second start ignored; sum = 0x23456789 with done exactly 4 cycles after the first accept; busy high for 4 cycles.
- Hold start = 1 in the DONE cycle with a = 0x80000000, b = 0x80000000, sub = 0 → new op accepted with no idle cycle; next result sum = 0, cout = 1, ovf = 1, zero = 1.
- Assert rst low during the 3rd RUN cycle → busy, done, sum and flags go to 0 immediately. After release, start with a = 1, b = 2 → sum = 3 after 4 cycles.
